// File: rtl/alarm_clock_pkg.sv
// Shared BCD time type, ring-state encoding and field limits
// for multi_alarm_clock.
package alarm_clock_pkg;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } bcd_time_t;

    typedef enum logic [1:0] {
        RS_IDLE   = 2'd0,
        RS_RING   = 2'd1,
        RS_SNOOZE = 2'd2
    } ring_state_e;

    function automatic logic [7:0] bcd_next(input logic [7:0] v,
                                            input logic [7:0] lim);
        if (v == lim)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_time_field.sv
// One two-digit BCD field wrapping at LIMIT; inc and cin both
// advance it, cout flags a carry into the next field.
module bcd_time_field
    import alarm_clock_pkg::*;
#(
    parameter logic [7:0] LIMIT = SEC_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       cin,
    output logic [7:0] value,
    output logic       cout
);

    assign cout = cin && (value == LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            value <= 8'h00;
        else if (inc || cin)
            value <= bcd_next(value, LIMIT);
    end

endmodule

// File: rtl/multi_alarm_clock.sv
// BCD clock with NUM_ALARMS alarms and a ring/snooze controller.
// Define SNOOZE_EN to build the snooze state and its timer.
module multi_alarm_clock
    import alarm_clock_pkg::*;
#(
    parameter int NUM_ALARMS  = 4,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    // a single-alarm build still gets a 1-bit select
    localparam int SW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick_1hz,
    input  logic                  settime,
    input  logic                  upsec,
    input  logic                  upmin,
    input  logic                  uphour,
    input  logic [SW-1:0]         alarm_sel,
    input  logic                  alarm_upsec,
    input  logic                  alarm_upmin,
    input  logic                  alarm_uphour,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    input  logic                  dismiss,
    input  logic                  snooze,
    output logic [23:0]           time_bcd,
    output logic [23:0]           alarm_bcd,
    output logic [NUM_ALARMS-1:0] match,
    output logic                  ringing,
    output logic [SW-1:0]         ring_id
);

    localparam logic [1:0] S_IDLE = RS_IDLE;
    localparam logic [1:0] S_RING = RS_RING;
    localparam int RW = $clog2(RING_SECS + 1);
    localparam logic [RW-1:0] RING_LOAD = RW'(RING_SECS);

    bcd_time_t             cur;
    bcd_time_t             alarm [NUM_ALARMS];
    logic [7:0]            t_ss, t_mm, t_hh;
    logic [7:0]            a_ss [NUM_ALARMS];
    logic [7:0]            a_mm [NUM_ALARMS];
    logic [7:0]            a_hh [NUM_ALARMS];
    logic                  run, ss_co, mm_co, hh_co_unused;
    logic                  tick_d;
    logic [NUM_ALARMS-1:0] hit;
    logic [SW-1:0]         first_hit;
    logic [1:0]            state;
    logic [RW-1:0]         ring_tmr;

`ifdef SNOOZE_EN
    localparam logic [1:0] S_SNOOZE = RS_SNOOZE;
    localparam int SNW = $clog2(SNOOZE_SECS + 1);
    localparam logic [SNW-1:0] SNOOZE_LOAD = SNW'(SNOOZE_SECS);
    logic [SNW-1:0] snz_tmr;
`else
    localparam int SNOOZE_SECS_UNUSED = SNOOZE_SECS;
    logic snooze_unused;
    assign snooze_unused = snooze;
`endif

    assign run = tick_1hz && !settime;

    bcd_time_field #(.LIMIT(SEC_MAX)) u_ss (
        .clk, .reset, .inc(settime && upsec), .cin(run),
        .value(t_ss), .cout(ss_co)
    );
    bcd_time_field #(.LIMIT(MIN_MAX)) u_mm (
        .clk, .reset, .inc(settime && upmin), .cin(ss_co),
        .value(t_mm), .cout(mm_co)
    );
    bcd_time_field #(.LIMIT(HOUR_MAX)) u_hh (
        .clk, .reset, .inc(settime && uphour), .cin(mm_co),
        .value(t_hh), .cout(hh_co_unused)
    );

    assign cur      = {t_hh, t_mm, t_ss};
    assign time_bcd = cur;

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_alarm
        logic       sel;
        logic [2:0] co_unused;
        assign sel = (alarm_sel == SW'(i));
        bcd_time_field #(.LIMIT(SEC_MAX)) u_ss (
            .clk, .reset, .inc(sel && alarm_upsec), .cin(1'b0),
            .value(a_ss[i]), .cout(co_unused[0])
        );
        bcd_time_field #(.LIMIT(MIN_MAX)) u_mm (
            .clk, .reset, .inc(sel && alarm_upmin), .cin(1'b0),
            .value(a_mm[i]), .cout(co_unused[1])
        );
        bcd_time_field #(.LIMIT(HOUR_MAX)) u_hh (
            .clk, .reset, .inc(sel && alarm_uphour), .cin(1'b0),
            .value(a_hh[i]), .cout(co_unused[2])
        );
        assign alarm[i] = {a_hh[i], a_mm[i], a_ss[i]};
        assign hit[i]   = alarm_en[i] && (alarm[i] == cur);
    end

    always_comb begin
        alarm_bcd = '0;
        for (int i = 0; i < NUM_ALARMS; i++)
            if (alarm_sel == SW'(i))
                alarm_bcd = alarm[i];
    end

    always_comb begin
        first_hit = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--)
            if (match[i])
                first_hit = SW'(i);
    end

    // compare one edge after a tick so only tick-driven time can match
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_d <= 1'b0;
            match  <= '0;
        end else begin
            tick_d <= run;
            match  <= tick_d ? hit : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            ring_id  <= '0;
            ring_tmr <= '0;
`ifdef SNOOZE_EN
            snz_tmr  <= '0;
`endif
        end else if (settime) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|match) begin
                        state    <= S_RING;
                        ring_id  <= first_hit;
                        ring_tmr <= RING_LOAD;
                    end
                end
                S_RING: begin
                    if (!alarm_en[ring_id] || dismiss) begin
                        state <= S_IDLE;
`ifdef SNOOZE_EN
                    end else if (snooze) begin
                        state   <= S_SNOOZE;
                        snz_tmr <= SNOOZE_LOAD;
`endif
                    end else if (tick_1hz) begin
                        if (ring_tmr <= RW'(1)) begin
                            state    <= S_IDLE;
                            ring_tmr <= '0;
                        end else begin
                            ring_tmr <= ring_tmr - RW'(1);
                        end
                    end
                end
`ifdef SNOOZE_EN
                S_SNOOZE: begin
                    if (!alarm_en[ring_id] || dismiss) begin
                        state <= S_IDLE;
                    end else if (|match) begin
                        state    <= S_RING;
                        ring_id  <= first_hit;
                        ring_tmr <= RING_LOAD;
                    end else if (tick_1hz) begin
                        if (snz_tmr <= SNW'(1)) begin
                            state    <= S_RING;
                            snz_tmr  <= '0;
                            ring_tmr <= RING_LOAD;
                        end else begin
                            snz_tmr <= snz_tmr - SNW'(1);
                        end
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ringing = (state == S_RING);

endmodule

// File: doc/multi_alarm_clock.md
MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
REQ-001 Parameter NUM_ALARMS, default 4, number of independent alarm registers (1..8).
REQ-002 Parameter RING_SECS, default 60, ring timeout in ticks before auto-stop.
REQ-003 Parameter SNOOZE_SECS, default 300, snooze countdown in ticks.
REQ-004 clk  in  1  system clock, single domain.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 tick_1hz  in  1  one-cycle enable pulse, once per second.
REQ-007 settime  in  1  level; freezes timekeeping and enables manual time set.
REQ-008 upsec, upmin, uphour  in  1 each  one-cycle pulses; increment the time field.
REQ-009 alarm_sel  in  $clog2(NUM_ALARMS)  alarm targeted by alarm_up* pulses.
REQ-010 alarm_upsec, alarm_upmin, alarm_uphour  in  1 each  one-cycle pulses; increment the selected alarm field.
REQ-011 alarm_en  in  NUM_ALARMS  per-alarm arm bits.
REQ-012 dismiss, snooze  in  1 each  one-cycle pulses from user controls.
REQ-013 time_bcd  out  24  current time {hh,mm,ss} as six BCD digits.
REQ-014 alarm_bcd  out  24  alarm[alarm_sel] as six BCD digits, combinational from the registers.
REQ-015 match  out  NUM_ALARMS  one-cycle match pulses.
REQ-016 ringing  out  1  alarm sounding; ring_id  out  $clog2(NUM_ALARMS)  alarm that is sounding.

Function
REQ-017 Time advances one second on each tick_1hz while settime=0, with BCD carry ss->mm->hh; 23:59:59 wraps to 00:00:00.
REQ-018 While settime=1, tick_1hz is ignored and up* pulses increment their field mod 60/60/24 with no carry (59->00, 23->00).
REQ-019 up* pulses while settime=0 are ignored.
REQ-020 Simultaneous upsec/upmin/uphour all apply in the same cycle.
REQ-021 alarm_up* modify only alarm[alarm_sel], in any mode, per-field mod 60/60/24 with no carry.
REQ-022 time_bcd updates on the edge sampling tick_1hz (latency 1).
REQ-023 match[i] pulses on the following edge iff that update came from a tick, new time == alarm[i], and alarm_en[i]=1; manual sets never produce match.
REQ-024 Ring FSM states: IDLE, RING, SNOOZE; ringing=1 only in RING.
REQ-025 IDLE -> RING on the edge after any match bit; ring_id = lowest matching index; ring timer loads RING_SECS.
REQ-026 RING: decrement ring timer per tick; dismiss -> IDLE; snooze -> SNOOZE, load SNOOZE_SECS; timer reaching 0 -> IDLE.
REQ-027 RING: new matches are ignored and ring_id holds.
REQ-028 SNOOZE: decrement per tick; reaching 0 -> RING with RING_SECS reload, same ring_id; dismiss -> IDLE; a new match -> RING with the new lowest index.
REQ-029 dismiss and snooze in the same cycle: dismiss wins.
REQ-030 alarm_en[ring_id] low in RING/SNOOZE -> IDLE on the next edge.
REQ-031 settime=1 forces the FSM to IDLE.
REQ-032 ring_id holds its last value in IDLE.

Reset
REQ-033 Reset sets time and all alarms to 00:00:00, match=0, ringing=0, ring_id=0, FSM=IDLE, and both timers to 0.
REQ-034 Reset mid-ring or mid-snooze stops ringing immediately (asynchronous).

Configuration
REQ-035 With SNOOZE_EN defined, the SNOOZE state and timer exist as in REQ-026..028.
REQ-036 Without SNOOZE_EN, the snooze input is ignored, the SNOOZE state and timer are not built, and SNOOZE_SECS is unused.

Structure
REQ-037 Package alarm_clock_pkg holds the BCD time struct (hh,mm,ss digit pairs), the ring-state enum, and limit constants 59/23.
REQ-038 Sub-module bcd_time_field implements one mod-N BCD field with inc, carry-in enable and carry-out; it is instantiated for the clock and for every alarm.

Verification
REQ-039 Set 23:59:58, settime=0, two ticks -> time_bcd 00:00:00, no carry glitch into hours.
REQ-040 settime=1 at 12:59:59, upsec -> 12:59:00 (no carry); tick in the same cycle ignored.
REQ-041 alarm[1]=alarm[2]=07:00:00, both enabled, time 06:59:59, tick -> match=0110 one edge later, ringing plus ring_id=1 one edge after that.
REQ-042 RING_SECS=3: ringing, three ticks -> IDLE; repeat with dismiss plus snooze together -> IDLE.
REQ-043 SNOOZE_EN, SNOOZE_SECS=2: snooze in RING, two ticks -> RING again with the same ring_id; without SNOOZE_EN, snooze has no effect.
REQ-044 Assert reset during RING -> ringing=0 immediately, time 00:00:00, alarms 00:00:00.
